// File: rtl/max_pool_fifo.sv
// 2x2 / stride-2 signed max pooling over a row-major multi-plane activation stream,
// using a half-width line FIFO to carry horizontal maxima from even rows to odd rows.
module max_pool_fifo #(
    parameter int IN_CHANNELS  = 4,
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_POOL     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  plane_done,
    output logic                  frame_done
);

    localparam int DEPTH = IMAGE_WIDTH / 2;
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int CH_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit POOL_EN = (MAX_POOL != 32'sd0);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(IN_CHANNELS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_t;

    function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    row_state_t            state_r, state_nxt_s;
    logic [COL_W-1:0]      col_r, col_nxt_s;
    logic [ROW_W-1:0]      row_r, row_nxt_s;
    logic [CH_W-1:0]       ch_r, ch_nxt_s;
    logic [PTR_W-1:0]      wr_ptr_r, wr_ptr_nxt_s;
    logic [PTR_W-1:0]      rd_ptr_r, rd_ptr_nxt_s;
    logic [DATA_WIDTH-1:0] h_reg_r;
    logic [DATA_WIDTH-1:0] fifo_mem_r [DEPTH];

    logic [DATA_WIDTH-1:0] hmax_s, head_s, out_data_s;
    logic                  col_odd_s, col_wrap_s, row_wrap_s, plane_last_s;
    logic                  push_s, pop_s, out_fire_s;

    // Next-state for the row FSM, position counters, FIFO pointers and output strobe.
    always_comb begin
        state_nxt_s  = state_r;
        col_nxt_s    = col_r;
        row_nxt_s    = row_r;
        ch_nxt_s     = ch_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        col_odd_s    = col_r[0];
        col_wrap_s   = (col_r == COL_LAST);
        row_wrap_s   = (row_r == ROW_LAST);
        plane_last_s = col_wrap_s && row_wrap_s;
        hmax_s       = smax(h_reg_r, data_in);
        head_s       = fifo_mem_r[rd_ptr_r];

        if (data_in_valid) begin
            if (col_wrap_s) begin
                col_nxt_s   = {COL_W{1'b0}};
                state_nxt_s = (state_r == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                if (row_wrap_s) begin
                    row_nxt_s = {ROW_W{1'b0}};
                    ch_nxt_s  = (ch_r == CH_LAST) ? {CH_W{1'b0}} : ch_r + CH_W'(1);
                end else begin
                    row_nxt_s = row_r + ROW_W'(1);
                end
            end else begin
                col_nxt_s = col_r + COL_W'(1);
            end

            if (POOL_EN && col_odd_s) begin
                case (state_r)
                    ROW_EVEN: push_s = 1'b1;
                    ROW_ODD:  pop_s  = 1'b1;
                    default:  push_s = 1'b0;
                endcase
            end else begin
                push_s = 1'b0;
            end
        end else begin
            col_nxt_s = col_r;
        end

        if (push_s) begin
            wr_ptr_nxt_s = (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (POOL_EN) begin
            out_fire_s = pop_s;
            out_data_s = smax(head_s, hmax_s);
        end else begin
            out_fire_s = data_in_valid;
            out_data_s = data_in;
        end
    end

    // State, counter and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ROW_EVEN;
            col_r    <= {COL_W{1'b0}};
            row_r    <= {ROW_W{1'b0}};
            ch_r     <= {CH_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            col_r    <= col_nxt_s;
            row_r    <= row_nxt_s;
            ch_r     <= ch_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
        end
    end

    // Left sample of each horizontal pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg_r <= {DATA_WIDTH{1'b0}};
        end else if (data_in_valid && !col_odd_s) begin
            h_reg_r <= data_in;
        end
    end

    // Line FIFO storage; contents are stale after reset but the pointers restart.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= hmax_s;
        end
    end

    // Registered outputs; data_out holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= {DATA_WIDTH{1'b0}};
            data_out_valid <= 1'b0;
            plane_done     <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            data_out_valid <= out_fire_s;
            plane_done     <= out_fire_s && plane_last_s;
            frame_done     <= out_fire_s && plane_last_s && (ch_r == CH_LAST);
            if (out_fire_s) begin
                data_out <= out_data_s;
            end
        end
    end

endmodule
